// File: rtl/muldiv_issue_pkg.sv
// muldiv_issue_pkg: M-extension func encodings and issue FSM states
package muldiv_issue_pkg;
  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} issue_state_t;
  function automatic logic is_div_op(input logic [3:0] f);
    return f inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction
endpackage

// File: rtl/muldiv_issue_div_special.sv
// muldiv_issue_div_special: RISC-V divide-by-zero and signed-overflow results
module muldiv_issue_div_special
  import muldiv_issue_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [3:0]      func_i,
  input  logic            word_op_i,
  output logic            hit_o,
  output logic [XLEN-1:0] value_o
);
  logic [XLEN-1:0] a_x;
  logic            zero, ovf, is_rem;
  // word ops look only at bits [31:0]; results sign-extend from bit 31
  always_comb begin
    a_x     = word_op_i ? {{(XLEN-32){a_i[31]}}, a_i[31:0]} : a_i;
    zero    = word_op_i ? (b_i[31:0] == 32'd0) : (b_i == '0);
    ovf     = (func_i inside {OP_DIV, OP_REM}) &
              (word_op_i ? (a_i[31:0] == 32'h8000_0000 && b_i[31:0] == '1)
                         : (a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1));
    is_rem  = func_i inside {OP_REM, OP_REMU};
    hit_o   = is_div_op(func_i) & (zero | ovf);
    value_o = zero ? (is_rem ? a_x : '1) : (is_rem ? '0 : a_x);
  end
endmodule

// File: rtl/muldiv_issue.sv
// muldiv_issue: issues one MUL/DIV op to its unit and buffers the result for writeback
module muldiv_issue
  import muldiv_issue_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int RD_W           = 5,
  parameter bit DIV_SPECIAL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] opr_a_i,
  input  logic [XLEN-1:0] opr_b_i,
  input  logic [3:0]      func_i,
  input  logic            word_op_i,
  input  logic [RD_W-1:0] rd_i,
  output logic            mul_valid_o,
  output logic            div_valid_o,
  input  logic            mul_ready_i,
  input  logic            div_ready_i,
  output logic [XLEN-1:0] unit_opr_a_o,
  output logic [XLEN-1:0] unit_opr_b_o,
  output logic [3:0]      unit_func_o,
  output logic            unit_word_op_o,
  input  logic            mul_res_valid_i,
  input  logic            div_res_valid_i,
  input  logic [XLEN-1:0] mul_res_i,
  input  logic [XLEN-1:0] div_res_i,
  output logic            mul_res_ready_o,
  output logic            div_res_ready_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [RD_W-1:0] wb_rd_o,
  input  logic            flush_i,
  output logic            flush_o,
  output logic            busy_o
);
  issue_state_t    state_q, state_d;
  logic [XLEN-1:0] opr_a_q, opr_a_d, opr_b_q, opr_b_d, wb_data_q, wb_data_d;
  logic [3:0]      func_q, func_d;
  logic            word_q, word_d, is_div_q, is_div_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            sp_hit, special, accept, unit_rdy, res_vld;
  logic [XLEN-1:0] sp_val, res;

  muldiv_issue_div_special #(.XLEN(XLEN)) u_special (
    .a_i(opr_a_i), .b_i(opr_b_i), .func_i(func_i), .word_op_i(word_op_i),
    .hit_o(sp_hit), .value_o(sp_val)
  );

  assign ex_ready_o = ~flush_i & (state_q == S_IDLE | (state_q == S_WB & wb_ready_i));
  assign accept     = ex_valid_i & ex_ready_o;
  assign special    = DIV_SPECIAL_EN & sp_hit;
  assign unit_rdy   = is_div_q ? div_ready_i : mul_ready_i;
  assign res_vld    = is_div_q ? div_res_valid_i : mul_res_valid_i;
  assign res        = is_div_q ? div_res_i : mul_res_i;

  // next state: unit handshakes, then accept overrides, then flush overrides everything
  always_comb begin
    state_d   = state_q;
    wb_data_d = wb_data_q;
    opr_a_d   = opr_a_q;
    opr_b_d   = opr_b_q;
    func_d    = func_q;
    word_d    = word_q;
    rd_d      = rd_q;
    is_div_d  = is_div_q;
    case (state_q)
      S_ISSUE: state_d = unit_rdy ? S_WAIT : S_ISSUE;
      S_WAIT: begin
        state_d   = res_vld ? S_WB : S_WAIT;
        wb_data_d = (res_vld & ~flush_i) ? res : wb_data_q;
      end
      S_WB: state_d = wb_ready_i ? S_IDLE : S_WB;
      default: ;
    endcase
    if (accept) begin
      opr_a_d   = opr_a_i;
      opr_b_d   = opr_b_i;
      func_d    = func_i;
      word_d    = word_op_i;
      rd_d      = rd_i;
      is_div_d  = is_div_op(func_i);
      state_d   = special ? S_WB : S_ISSUE;
      wb_data_d = special ? sp_val : wb_data_q;
    end
    if (flush_i) state_d = S_IDLE;
  end

  // state and latched operand/result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      opr_a_q   <= '0;
      opr_b_q   <= '0;
      func_q    <= '0;
      word_q    <= 1'b0;
      rd_q      <= '0;
      is_div_q  <= 1'b0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      opr_a_q   <= opr_a_d;
      opr_b_q   <= opr_b_d;
      func_q    <= func_d;
      word_q    <= word_d;
      rd_q      <= rd_d;
      is_div_q  <= is_div_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign mul_valid_o     = state_q == S_ISSUE & ~is_div_q;
  assign div_valid_o     = state_q == S_ISSUE & is_div_q;
  assign mul_res_ready_o = state_q == S_WAIT & ~is_div_q;
  assign div_res_ready_o = state_q == S_WAIT & is_div_q;
  assign unit_opr_a_o    = opr_a_q;
  assign unit_opr_b_o    = opr_b_q;
  assign unit_func_o     = func_q;
  assign unit_word_op_o  = word_q;
  assign wb_valid_o      = state_q == S_WB;
  assign wb_data_o       = wb_data_q;
  assign wb_rd_o         = rd_q;
  assign flush_o         = flush_i;
  assign busy_o          = state_q != S_IDLE;
endmodule

// File: doc/muldiv_issue.md
Name: muldiv_issue

Overview:
- Initiator side of the M-extension execute handshake.
- Accepts one MUL/DIV/REM op at a time from the execute dispatch stage and routes it to the multiplier or the divider over their valid/ready operand and result interfaces.
- Captures the result into a one-entry writeback buffer and presents it to writeback with its rd address.
- Resolves RISC-V divide special cases (divide by zero, signed overflow) locally without engaging the divider.

Parameters:
- XLEN, 64, operand/result width.
- RD_W, 5, destination register address width.
- DIV_SPECIAL_EN, 1, when 1 resolve div-by-zero/overflow locally; when 0 all div ops go to the divider.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- ex_valid_i  in  1  op offered by dispatch
- ex_ready_o  out  1  op accepted when ex_valid_i & ex_ready_o
- opr_a_i / opr_b_i  in  XLEN  rs1 / rs2 values
- func_i  in  4  OP_MUL..OP_REMU
- word_op_i  in  1  W-form (32-bit, sign-extended result)
- rd_i  in  RD_W  destination register
- mul_valid_o / div_valid_o  out  1  operand offer to unit
- mul_ready_i / div_ready_i  in  1  unit accepts operands
- unit_opr_a_o / unit_opr_b_o  out  XLEN  latched operands, shared by both units
- unit_func_o  out  4  latched func
- unit_word_op_o  out  1  latched word flag
- mul_res_valid_i / div_res_valid_i  in  1  unit result valid
- mul_res_i / div_res_i  in  XLEN  unit result
- mul_res_ready_o / div_res_ready_o  out  1  result consumed
- wb_valid_o  out  1  result for writeback
- wb_ready_i  in  1  writeback accepts
- wb_data_o  out  XLEN  result
- wb_rd_o  out  RD_W  destination
- flush_i  in  1  pipeline flush
- flush_o  out  1  flush to units, equal to flush_i
- busy_o  out  1  state != S_IDLE

Behaviour:
- Reset: state=S_IDLE; all latched regs 0; every valid/ready output 0 except ex_ready_o=1; wb_data_o=0; wb_rd_o=0.
- States: S_IDLE, S_ISSUE, S_WAIT, S_WB.
- ex_ready_o = ~flush_i & ((state==S_IDLE) | (state==S_WB & wb_ready_i)).
  - S_WB with wb_ready_i and new ex_valid_i: retire the old result and accept the new op in the same cycle (back-to-back).
- Accept: latch opr_a, opr_b, func, word_op, rd; set is_div = func in {DIV, DIVU, REM, REMU}.
- Special-case detection runs on the incoming operands at accept. Word ops compare bits [31:0] only.
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → dividend.
  - Signed overflow (DIV/REM, dividend = most-negative, divisor = -1): DIV → dividend; REM → 0.
  - Word results are sign-extended from bit 31.
  - With DIV_SPECIAL_EN=1 and a special case: load the wb buffer directly, next state S_WB (wb_valid_o one cycle after accept).
  - Otherwise next state is S_ISSUE.
- S_ISSUE: mul_valid_o = ~is_div, div_valid_o = is_div; unit_* driven from latched regs. Go to S_WAIT on valid & the selected unit's ready. Operands stay stable until the handshake fires.
- S_WAIT: the selected unit's res_ready_o = 1, the other 0. On res_valid_i: capture data into wb_data_o (rd already latched), go to S_WB. Result valid in the same cycle as flush_i is discarded.
- S_WB: wb_valid_o = 1. wb_ready_i → S_IDLE, or stay in S_WB with a new op if one is accepted the same cycle via a special case; a non-special new op goes to S_ISSUE.
- Flush, any state: next state S_IDLE, wb buffer dropped, wb_valid_o deasserted next cycle. The op offered by ex_valid_i is not accepted that cycle. The units clear themselves via flush_o.
- wb_valid_o, mul/div_valid_o and res_ready_o are pure functions of state and latched regs; no combinational path from wb_ready_i to wb_valid_o.
- No result fields are modified except the local special-case values; unit results pass through unchanged.

Decomposition:
- cpu_consts: M-op func encodings OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, and issue_state_t {S_IDLE, S_ISSUE, S_WAIT, S_WB}.
- Sub-module div_special: combinational, takes (a, b, func, word_op) and returns (hit, value). Reused by divider verification as a golden model.

Test Plan:
- MUL a=3, b=-4, multiplier model → mul_valid_o held until mul_ready_i; wb_data_o=0xFFFFFFFFFFFFFFF4, wb_rd_o=latched rd.
- DIVU a=7, b=0 → div_valid_o never asserts; wb_valid_o one cycle after accept, wb_data_o=0xFFFFFFFFFFFFFFFF. REMU 7/0 → 7.
- DIV a=0x8000000000000000, b=-1 → wb_data_o=0x8000000000000000; REM same operands → 0. DIVW a=0x80000000, b=0xFFFFFFFF → 0xFFFFFFFF80000000.
- wb_ready_i low 5 cycles → wb_valid_o/wb_data_o stable, ex_ready_o=0. Then wb_ready_i=1 with a new MULW offered → retire and accept in the same cycle.
- flush_i in S_WAIT coincident with mul_res_valid_i → no wb_valid_o, state S_IDLE next cycle, flush_o=1 that cycle.
- resetn asserted in S_ISSUE → outputs return to reset values immediately; after release a new op is accepted normally.
